// File: rtl/fact_host.sv
// Bus master that drives an external factorial core through its register block:
// programs the operand, waits for the core's interrupt (with timeout), reads the 64-bit result.
`timescale 1ns/1ps
module fact_host #(
  parameter logic [7:0] ADDR_BASE   = 8'h20,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] operand,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] result,
  output logic        M_req,
  output logic        M_wr,
  output logic [7:0]  M_address,
  output logic [31:0] M_dout,
  input  logic        M_grant,
  input  logic [31:0] M_din,
  input  logic        f_interrupt
);

  typedef enum logic [3:0] {
    IDLE, REQ_W, WR_OP, WR_IE, WR_GO, WAIT_INT, REQ_R, RD_LO, RD_HI, WR_CLR, FIN
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [31:0] op_reg;
  logic [15:0] timer;

  // Bus outputs are loaded on the transition into each state, so they describe the
  // current state and simply hold while the arbiter withholds the grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      op_reg    <= '0;
      timer     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      result    <= '0;
      M_req     <= 1'b0;
      M_wr      <= 1'b0;
      M_address <= '0;
      M_dout    <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_reg    <= operand;
          busy      <= 1'b1;
          M_req     <= 1'b1;
          M_wr      <= 1'b0;
          M_address <= ADDR_BASE + 8'd2;
          M_dout    <= '0;
          state     <= REQ_W;
        end
        REQ_W: if (M_grant) begin
          M_wr      <= 1'b1;
          M_address <= ADDR_BASE;
          M_dout    <= op_reg;
          state     <= WR_OP;
        end
        WR_OP: if (M_grant) begin
          M_address <= ADDR_BASE + 8'd1;
          M_dout    <= 32'h1;
          state     <= WR_IE;
        end
        WR_IE: if (M_grant) begin
          M_address <= ADDR_BASE + 8'd3;
          M_dout    <= 32'h1;
          state     <= WR_GO;
        end
        WR_GO: if (M_grant) begin
          M_req  <= 1'b0;
          M_wr   <= 1'b0;
          M_dout <= '0;
          timer  <= '0;
          state  <= WAIT_INT;
        end
        // Interrupt is tested first so it wins over a simultaneous timeout.
        WAIT_INT: begin
          if (f_interrupt) begin
            timer     <= '0;
            M_req     <= 1'b1;
            M_wr      <= 1'b0;
            M_address <= ADDR_BASE + 8'd5;
            state     <= REQ_R;
          end else if (timer == TIMEOUT_LAST) begin
            timer <= '0;
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        REQ_R: if (M_grant) begin
          state <= RD_LO;
        end
        RD_LO: if (M_grant) begin
          result[31:0] <= M_din;
          M_address    <= ADDR_BASE + 8'd6;
          state        <= RD_HI;
        end
        RD_HI: if (M_grant) begin
          result[63:32] <= M_din;
          M_wr          <= 1'b1;
          M_address     <= ADDR_BASE + 8'd4;
          M_dout        <= 32'h1;
          state         <= WR_CLR;
        end
        WR_CLR: if (M_grant) begin
          M_req  <= 1'b0;
          M_wr   <= 1'b0;
          M_dout <= '0;
          state  <= FIN;
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_host.sv
// Directed bench for fact_host: register-block slave with a factorial core model,
// expected-transaction queue and result scoreboard checked on every falling edge.
`timescale 1ns/1ps
module tb_fact_host;

  logic        clk = 1'b0;
  logic        reset_n, start, M_grant, f_interrupt;
  logic [31:0] operand, M_din, M_dout;
  logic        busy, done, error, M_req, M_wr;
  logic [63:0] result;
  logic [7:0]  M_address;

  fact_host #(.ADDR_BASE(8'h20), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .operand(operand),
    .busy(busy), .done(done), .error(error), .result(result),
    .M_req(M_req), .M_wr(M_wr), .M_address(M_address), .M_dout(M_dout),
    .M_grant(M_grant), .M_din(M_din), .f_interrupt(f_interrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic        wr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          checking = 0;
  bit          expect_done = 0;
  bit          expect_error = 0;
  logic [63:0] exp_result = '0;

  function automatic logic [63:0] fact64(input logic [31:0] n);
    logic [63:0] f;
    f = 64'd1;
    if (n >= 32'd66) return 64'd0;
    for (int i = 2; i <= int'(n); i++) f = f * 64'(i);
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Slave side of the register block plus a behavioural factorial core.
  logic        slave_ie, irq;
  logic [31:0] slave_op;
  logic [63:0] fact_val;
  int          irq_cnt;
  int          irq_delay = 5;
  bit          irq_enable = 1;

  assign f_interrupt = irq;

  always_comb begin
    fact_val = fact64(slave_op);
    M_din    = 32'h0;
    case (M_address)
      8'h22:   M_din = {31'b0, irq};
      8'h25:   M_din = fact_val[31:0];
      8'h26:   M_din = fact_val[63:32];
      default: M_din = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      irq      <= 1'b0;
      irq_cnt  <= 0;
      slave_ie <= 1'b0;
      slave_op <= '0;
    end else begin
      if (irq_cnt != 0) begin
        irq_cnt <= irq_cnt - 1;
        if (irq_cnt == 1) irq <= 1'b1;
      end
      if (M_req && M_grant && M_wr) begin
        case (M_address)
          8'h20: slave_op <= M_dout;
          8'h21: slave_ie <= M_dout[0];
          8'h23: if (slave_ie && irq_enable) irq_cnt <= irq_delay;
          8'h24: irq <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // Single compare process: bus transfers against the expected queue, idle write data,
  // and done/error pulses against the scoreboard.
  txn_t t;
  always @(negedge clk) begin
    if (checking) begin
      if (M_req && M_grant) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL bus_unexpected: got addr 0x%0h wr %0b, required no transfer", M_address, M_wr);
        end else begin
          t = exp_q.pop_front();
          checkOutput("bus_addr", 64'(M_address), 64'(t.addr));
          checkOutput("bus_wr", 64'(M_wr), 64'(t.wr));
          if (t.wr) checkOutput("bus_wdata", 64'(M_dout), 64'(t.data));
        end
      end
      if (!M_wr) checkOutput("dout_idle", 64'(M_dout), 64'd0);
      if (done) begin
        checkOutput("done_allowed", 64'(expect_done), 64'd1);
        checkOutput("done_result", result, exp_result);
        expect_done = 0;
      end
      if (error) begin
        checkOutput("error_allowed", 64'(expect_error), 64'd1);
        expect_error = 0;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] op, input bit with_irq);
    @(negedge clk);
    start   = 1'b1;
    operand = op;
    exp_q.push_back('{8'h22, 1'b0, 32'h0});
    exp_q.push_back('{8'h20, 1'b1, op});
    exp_q.push_back('{8'h21, 1'b1, 32'h1});
    exp_q.push_back('{8'h23, 1'b1, 32'h1});
    if (with_irq) begin
      exp_q.push_back('{8'h25, 1'b0, 32'h0});
      exp_q.push_back('{8'h25, 1'b0, 32'h0});
      exp_q.push_back('{8'h26, 1'b0, 32'h0});
      exp_q.push_back('{8'h24, 1'b1, 32'h1});
      expect_done = 1;
      exp_result  = fact64(op);
    end else begin
      expect_error = 1;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitEnd(input int budget, output bit got_done, output bit got_err);
    got_done = 0;
    got_err  = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || error) begin
        got_done = done;
        got_err  = error;
        break;
      end
    end
    if (!got_done && !got_err) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_end: no done/error within %0d cycles", budget);
    end
  endtask

  task automatic waitGoWrite(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (M_req && M_grant && M_address == 8'h23) begin
        seen = 1;
        break;
      end
    end
    checkOutput("go_write_seen", 64'(seen), 64'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_error"}, 64'(error), 64'd0);
    checkOutput({tag, "_req"}, 64'(M_req), 64'd0);
    checkOutput({tag, "_wr"}, 64'(M_wr), 64'd0);
    checkOutput({tag, "_addr"}, 64'(M_address), 64'd0);
    checkOutput({tag, "_dout"}, 64'(M_dout), 64'd0);
    checkOutput({tag, "_result"}, result, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  bit got_done, got_err, found;
  int cyc;

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    operand = '0;
    M_grant = 1'b1;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    checkOutput("model_fact20", fact64(32'd20), 64'h21C3677C82B40000);
    reset_n  = 1'b1;
    checking = 1;

    // Grant tied high, operand 20.
    irq_delay = 5;
    applyStimulus(32'd20, 1);
    checkOutput("t1_busy", 64'(busy), 64'd1);
    waitEnd(200, got_done, got_err);
    checkOutput("t1_done", 64'(got_done), 64'd1);
    checkOutput("t1_busy_at_done", 64'(busy), 64'd0);
    checkOutput("t1_result", result, 64'h21C3677C82B40000);
    @(negedge clk);
    checkOutput("t1_done_pulse", 64'(done), 64'd0);

    // Grant withheld for three cycles during the INTR_EN write.
    applyStimulus(32'd5, 1);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (M_req && M_wr && M_address == 8'h21) begin
        found = 1;
        break;
      end
    end
    checkOutput("t2_reached_wr_ie", 64'(found), 64'd1);
    M_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("t2_stall_req", 64'(M_req), 64'd1);
      checkOutput("t2_stall_wr", 64'(M_wr), 64'd1);
      checkOutput("t2_stall_addr", 64'(M_address), 64'h21);
      checkOutput("t2_stall_dout", 64'(M_dout), 64'h1);
    end
    M_grant = 1'b1;
    waitEnd(200, got_done, got_err);
    checkOutput("t2_done", 64'(got_done), 64'd1);
    checkOutput("t2_result", result, 64'h78);

    // Interrupt arrives on the very cycle the timeout would fire: interrupt wins.
    irq_delay = 15;
    applyStimulus(32'd10, 1);
    waitEnd(200, got_done, got_err);
    checkOutput("t3_done", 64'(got_done), 64'd1);
    checkOutput("t3_no_error", 64'(got_err), 64'd0);
    checkOutput("t3_result", result, 64'h375F00);

    // No interrupt at all: timeout 16 cycles after WAIT_INT entry, no reads.
    irq_enable = 0;
    applyStimulus(32'd9, 0);
    waitGoWrite(50);
    @(negedge clk);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (error) begin
        cyc = i;
        break;
      end
    end
    checkOutput("t4_timeout_cycles", 64'(cyc), 64'd16);
    checkOutput("t4_busy", 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput("t4_error_pulse", 64'(error), 64'd0);
    repeat (5) @(negedge clk);
    checkOutput("t4_no_req", 64'(M_req), 64'd0);
    checkOutput("t4_result_held", result, 64'h375F00);
    irq_enable = 1;

    // Second start while busy is ignored.
    irq_delay = 5;
    applyStimulus(32'd4, 1);
    repeat (2) @(negedge clk);
    checkOutput("t5_busy_before_restart", 64'(busy), 64'd1);
    start   = 1'b1;
    operand = 32'd7;
    @(negedge clk);
    start = 1'b0;
    waitEnd(200, got_done, got_err);
    checkOutput("t5_done", 64'(got_done), 64'd1);
    checkOutput("t5_result", result, 64'h18);

    // Reset while waiting for the interrupt, then a fresh operation.
    irq_delay = 12;
    applyStimulus(32'd6, 1);
    waitGoWrite(50);
    repeat (3) @(negedge clk);
    checkOutput("t6_waiting_busy", 64'(busy), 64'd1);
    checkOutput("t6_waiting_req", 64'(M_req), 64'd0);
    reset_n = 1'b0;
    exp_q.delete();
    expect_done = 0;
    @(negedge clk);
    checkAllZero("t6_reset");
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    irq_delay = 5;
    applyStimulus(32'd3, 1);
    waitEnd(200, got_done, got_err);
    checkOutput("t6_done", 64'(got_done), 64'd1);
    checkOutput("t6_result", result, 64'h6);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fact_host.md
FACT_HOST -- requirements
Module: fact_host

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 8'h20, base address of the factorial register block.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4096, maximum cycles waiting for f_interrupt (16-bit counter).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to compute operand!.
REQ-006 SHALL have port operand  input  32  factorial argument, captured on accepted start.
REQ-007 SHALL have port busy  output  1  high from accepted start until done/error.
REQ-008 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-009 SHALL have port error  output  1  one-cycle pulse on timeout.
REQ-010 SHALL have port result  output  64  {RESULT_H, RESULT_L}, held until next done.
REQ-011 SHALL have port M_req  output  1  bus request.
REQ-012 SHALL have port M_wr  output  1  1 = write, 0 = read.
REQ-013 SHALL have port M_address  output  8  target register address.
REQ-014 SHALL have port M_dout  output  32  write data.
REQ-015 SHALL have port M_grant  input  1  bus grant from arbiter.
REQ-016 SHALL have port M_din  input  32  read data, valid in the cycle address is driven with grant.
REQ-017 SHALL have port f_interrupt  input  1  level interrupt from factorial core.

Function
REQ-018 Register offsets from ADDR_BASE: +0 OPERAND, +1 INTR_EN, +2 STATUS, +3 START, +4 INTR_CLR, +5 RESULT_L, +6 RESULT_H.
REQ-019 A bus cycle completes at a rising edge where M_req=1 and M_grant=1; write data/read data transfer at that edge.
REQ-020 States: IDLE, REQ_W, WR_OP, WR_IE, WR_GO, WAIT_INT, REQ_R, RD_LO, RD_HI, WR_CLR, FIN.
REQ-021 IDLE: start=1 captures operand, sets busy, goes REQ_W next cycle; start while busy ignored.
REQ-022 REQ_W: M_req=1, M_wr=0, M_address=base+2; advances to WR_OP on first cycle M_grant=1.
REQ-023 WR_OP writes operand to +0; WR_IE writes 32'h1 to +1; WR_GO writes 32'h1 to +3; each one cycle with grant.
REQ-024 Any bus state with M_grant=0 SHALL stall, holding M_req, M_wr, M_address, M_dout unchanged.
REQ-025 After WR_GO: M_req=0, M_wr=0, enter WAIT_INT, timeout counter cleared to 0.
REQ-026 WAIT_INT: counter increments each cycle; f_interrupt=1 -> REQ_R; counter reaching TIMEOUT_CYC-1 without interrupt -> error pulse, busy=0, IDLE, M_req=0.
REQ-027 f_interrupt and timeout in the same cycle: interrupt wins.
REQ-028 REQ_R: M_req=1, M_wr=0, address base+5; on grant RD_LO latches M_din into result[31:0], then RD_HI (base+6) latches result[63:32].
REQ-029 WR_CLR writes 32'h1 to base+4; then FIN: M_req=0, M_wr=0, done=1 one cycle, busy=0, return IDLE.
REQ-030 result SHALL update only on completed RD_LO/RD_HI transfers of the current operation; done never precedes both.
REQ-031 M_wr SHALL be 1 only in WR_OP, WR_IE, WR_GO, WR_CLR; M_dout=0 outside write states.
REQ-032 Operand 0 and values >20 SHALL be issued unchanged; no range checking in this block.
REQ-033 Counter SHALL not wrap; it is only active in WAIT_INT.

Reset
REQ-034 reset_n=0 at a rising edge SHALL force IDLE; busy, done, error, M_req, M_wr = 0; M_address=8'h00; M_dout=0; result=0; counter=0.
REQ-035 Reset mid-operation (any state) SHALL abort with no done/error pulse; M_req drops at that edge.

Verification
REQ-036 Grant tied 1, slave model, start with operand=20 -> writes 0x14@0x20, 0x1@0x21, 0x1@0x23; after interrupt reads 0x25/0x26, writes 0x1@0x24; result=64'h21C3677C82B40000, done one cycle.
REQ-037 operand=5, grant deasserted 3 cycles during WR_IE -> bus signals frozen 3 cycles, then completes; result=64'h78.
REQ-038 f_interrupt never asserted, TIMEOUT_CYC=16 -> error pulse 16 cycles after WAIT_INT entry, busy=0, no reads issued.
REQ-039 start pulsed again while busy with operand=7 -> ignored; result reflects first operand only.
REQ-040 reset_n=0 for one cycle during WAIT_INT -> all outputs zero next edge, no done; fresh start operand=3 -> result=64'h6.
